mmio_bus_arbiter: RTL and testbench
===================================

MMIO_BUS_ARBITER -- requirements
Module: mmio_bus_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- BRAM_BASE, 32'h0000_0000, BRAM region low bound (inclusive)
- BRAM_TOP, 32'h0000_07FF, BRAM region high bound (inclusive)
- GPIO_BASE, 32'hFFFF_FFF0, GPIO region low bound (inclusive)
- GPIO_TOP, 32'hFFFF_FFF3, GPIO region high bound (inclusive)
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state updates on rising edge
- reset, in, 1, asynchronous, active-high reset
- mN_req (N=0,1), in, 1, master N requests a transfer
- mN_we, in, 1, master N write (1) or read (0)
- mN_addr, in, 32, master N byte address
- mN_wdata, in, 32, master N write data
- mN_mask, in, 4, master N byte enables
- mN_gnt, out, 1, one-cycle pulse: master N command accepted
- mN_rvalid, out, 1, one-cycle pulse: master N transfer complete
- mN_rdata, out, 32, read data, valid only while mN_rvalid=1
- mN_err, out, 1, unmapped address; valid only while mN_rvalid=1
- s_addr / s_wdata / s_mask, out, 32/32/4, registered command to slaves
- s_we, out, 1, slave write strobe
- bram_sel / gpio_sel, out, 1, region select to BRAM / GPIO
- bram_rdata / gpio_rdata, in, 32, slave read data, 1-cycle synchronous latency

Function
REQ-003 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when either mN_req=1, else stay; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-004 On the IDLE->ACCESS edge, the winner's addr/wdata/mask/we, master id and decoded region SHALL be registered; mN_req is sampled only in IDLE.
REQ-005 mN_gnt SHALL be 1 for exactly the ACCESS cycle, for the winner only.
REQ-006 During ACCESS only: s_addr/s_wdata/s_mask = registered command; bram_sel or gpio_sel = 1 for the decoded region; s_we = registered we AND region mapped; all 0 in IDLE and RESP.
REQ-007 During RESP: winner's mN_rvalid=1; mN_rdata = bram_rdata or gpio_rdata by registered region for reads, 32'h0 for writes and unmapped; other master's rvalid=0.
REQ-008 Latency: req sampled in IDLE at cycle n -> gnt in n+1 -> rvalid in n+2; throughput one transfer per 3 cycles.
REQ-009 Decode: inclusive bounds; BRAM checked before GPIO; address in neither -> no select, no s_we, mN_err=1 with rvalid, rdata=0.
REQ-010 Boundaries: 32'h0000_07FF maps BRAM, 32'h0000_0800 unmapped; 32'hFFFF_FFEF unmapped, 32'hFFFF_FFF3 GPIO.
REQ-011 A master dropping req before being sampled in IDLE SHALL cause no transfer; req held after rvalid starts a new transfer from the next IDLE.
REQ-012 Registered command SHALL not change between ACCESS and RESP regardless of mN_* input activity.

Reset
REQ-013 reset=1 SHALL immediately force IDLE, clear all outputs to 0 (including s_we and selects mid-ACCESS) and clear the round-robin pointer to "last granted = m1".
REQ-014 A transfer interrupted by reset SHALL produce no rvalid and no later slave write.

Configuration
REQ-015 Macro ARB_ROUND_ROBIN_EN: defined -> on simultaneous requests grant the master not granted most recently (pointer updated on each grant); undefined -> fixed priority, m0 always wins ties; single requester always granted in both.

Verification
REQ-016 m0 read 32'h0000_0010, bram_rdata=32'hDEADBEEF -> m0_gnt cycle n+1, bram_sel=1, s_we=0; m0_rvalid cycle n+2 with m0_rdata=32'hDEADBEEF, err=0.
REQ-017 m1 write 32'hFFFF_FFF0, wdata=32'h1, mask=4'hF -> gpio_sel=1, s_we=1 for exactly one cycle; m1_rvalid next cycle, rdata=0, err=0.
REQ-018 m0 read 32'h0000_0800 -> no select, s_we never 1; m0_rvalid with m0_err=1, rdata=0.
REQ-019 Both req held continuously for 4 transfers -> fixed priority: m0,m0,m0,m0; ARB_ROUND_ROBIN_EN: m0,m1,m0,m1.
REQ-020 reset asserted during ACCESS of a BRAM write -> s_we falls with reset, no rvalid, FSM in IDLE; first transfer after release completes normally.

Source files
------------

// File: rtl/mmio_bus_arbiter_if.sv
// Bundle of the arbiter's master-side request/response signals and its
// slave-side command/read-data signals.
//   slave  : the arbiter's own view (accepts master requests, drives slaves)
//   master : the surrounding environment (bus masters plus memory slaves)
interface mmio_bus_arbiter_if;
  // Master 0 request/response
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_mask;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;

  // Master 1 request/response
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_mask;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;

  // Shared slave command and per-region read data
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_mask;
  logic        s_we;
  logic        bram_sel;
  logic        gpio_sel;
  logic [31:0] bram_rdata;
  logic [31:0] gpio_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_mask,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_mask,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output s_addr, s_wdata, s_mask, s_we, bram_sel, gpio_sel,
    input  bram_rdata, gpio_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_mask,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_mask,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  s_addr, s_wdata, s_mask, s_we, bram_sel, gpio_sel,
    output bram_rdata, gpio_rdata
  );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Two-master MMIO arbiter in front of a BRAM region and a GPIO region.
// Each transfer takes three cycles: IDLE (sample requests), ACCESS (grant
// pulse, command on the slave bus), RESP (rvalid pulse with read data or
// error). Addresses outside both regions complete with err=1 and never
// reach a slave.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate between masters
// on simultaneous requests; without it master 0 wins every tie.
module mmio_bus_arbiter #(
  parameter logic [31:0] BRAM_BASE = 32'h0000_0000,
  parameter logic [31:0] BRAM_TOP  = 32'h0000_07FF,
  parameter logic [31:0] GPIO_BASE = 32'hFFFF_FFF0,
  parameter logic [31:0] GPIO_TOP  = 32'hFFFF_FFF3
) (
  input  logic               clk,
  input  logic               reset,
  mmio_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_BRAM = 2'd1,
    REG_GPIO = 2'd2
  } region_t;

  // Offset form keeps inclusive bounds correct even when a base is zero.
  function automatic region_t decode(input logic [31:0] addr);
    region_t r;
    r = REG_NONE;
    if ((addr - BRAM_BASE) <= (BRAM_TOP - BRAM_BASE)) begin
      r = REG_BRAM;
    end else if ((addr - GPIO_BASE) <= (GPIO_TOP - GPIO_BASE)) begin
      r = REG_GPIO;
    end
    return r;
  endfunction

  state_t      state_q;
  state_t      state_d;
  logic        any_req;
  logic        win_m1;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [3:0]  win_mask;
  logic        accept;

  // Command captured when a request is accepted in IDLE
  logic        id_p1;
  logic        we_p1;
  logic [31:0] addr_p1;
  logic [31:0] wdata_p1;
  logic [3:0]  mask_p1;
  region_t     region_p1;
  logic [31:0] resp_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_m1;

  // Remember who was granted last; reset says m1 so m0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_m1 <= 1'b1;
    end else if (accept) begin
      last_m1 <= win_m1;
    end
  end
`endif

  // Pick the winner among current requesters and mux its command.
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (bus.m0_req && bus.m1_req) begin
      win_m1 = ~last_m1;
    end else begin
      win_m1 = bus.m1_req;
    end
`else
    win_m1 = bus.m1_req & ~bus.m0_req;
`endif
    win_we    = win_m1 ? bus.m1_we    : bus.m0_we;
    win_addr  = win_m1 ? bus.m1_addr  : bus.m0_addr;
    win_wdata = win_m1 ? bus.m1_wdata : bus.m0_wdata;
    win_mask  = win_m1 ? bus.m1_mask  : bus.m0_mask;
    accept    = (state_q == IDLE) && any_req;
  end

  // FSM state register; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE waits for a request, then ACCESS and RESP run one cycle each.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hold the accepted command stable through ACCESS and RESP; outputs are
  // gated by state so these data registers need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      id_p1     <= win_m1;
      we_p1     <= win_we;
      addr_p1   <= win_addr;
      wdata_p1  <= win_wdata;
      mask_p1   <= win_mask;
      region_p1 <= decode(win_addr);
    end
  end

  // Drive slave command in ACCESS and the response in RESP; zero otherwise.
  always_comb begin
    bus.s_addr    = '0;
    bus.s_wdata   = '0;
    bus.s_mask    = '0;
    bus.s_we      = 1'b0;
    bus.bram_sel  = 1'b0;
    bus.gpio_sel  = 1'b0;
    bus.m0_gnt    = 1'b0;
    bus.m1_gnt    = 1'b0;
    bus.m0_rvalid = 1'b0;
    bus.m1_rvalid = 1'b0;
    bus.m0_rdata  = '0;
    bus.m1_rdata  = '0;
    bus.m0_err    = 1'b0;
    bus.m1_err    = 1'b0;
    resp_data     = '0;
    case (state_q)
      ACCESS: begin
        bus.s_addr   = addr_p1;
        bus.s_wdata  = wdata_p1;
        bus.s_mask   = mask_p1;
        bus.bram_sel = (region_p1 == REG_BRAM);
        bus.gpio_sel = (region_p1 == REG_GPIO);
        bus.s_we     = we_p1 && (region_p1 != REG_NONE);
        bus.m0_gnt   = ~id_p1;
        bus.m1_gnt   = id_p1;
      end
      RESP: begin
        if (!we_p1) begin
          if (region_p1 == REG_BRAM) begin
            resp_data = bus.bram_rdata;
          end else if (region_p1 == REG_GPIO) begin
            resp_data = bus.gpio_rdata;
          end
        end
        if (id_p1) begin
          bus.m1_rvalid = 1'b1;
          bus.m1_rdata  = resp_data;
          bus.m1_err    = (region_p1 == REG_NONE);
        end else begin
          bus.m0_rvalid = 1'b1;
          bus.m0_rdata  = resp_data;
          bus.m0_err    = (region_p1 == REG_NONE);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Self-checking bench for mmio_bus_arbiter: directed vector table, hand
// sequences for arbitration order and reset mid-transfer, and a random
// phase checked against a transaction-level model.
module tb_mmio_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic preload;

  always #5 clk = ~clk;

  mmio_bus_arbiter_if bus();

  mmio_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic        gnt0;
    logic        gnt1;
    logic        rv0;
    logic        rv1;
    logic        err0;
    logic        err1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] saddr;
    logic [31:0] swdata;
    logic [3:0]  smask;
    logic        swe;
    logic        bsel;
    logic        gsel;
  } obs_t;

  typedef struct {
    int          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          region;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  int we_cnt = 0;

  logic [31:0] mem [512];
  logic [31:0] gpio_reg;
  logic [31:0] mdl_mem [512];
  logic [31:0] mdl_gpio;
  bit          mdl_last_m1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)   return 32'hDEAD_BEEF;
    if (i == 511) return 32'h1234_5678;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] mk);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (mk[b]) r[8*b +: 8] = nw[8*b +: 8];
    end
    return r;
  endfunction

  // 0 = unmapped, 1 = BRAM, 2 = GPIO
  function automatic int region_of(input logic [31:0] a);
    if (a <= 32'h0000_07FF) return 1;
    if (a >= 32'hFFFF_FFF0 && a <= 32'hFFFF_FFF3) return 2;
    return 0;
  endfunction

  // Slave memories with one-cycle synchronous read latency.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      gpio_reg <= '0;
    end else begin
      if (bus.bram_sel) begin
        bus.bram_rdata <= mem[bus.s_addr[10:2]];
        if (bus.s_we) mem[bus.s_addr[10:2]] <= merge(mem[bus.s_addr[10:2]], bus.s_wdata, bus.s_mask);
      end
      if (bus.gpio_sel) begin
        bus.gpio_rdata <= gpio_reg;
        if (bus.s_we) gpio_reg <= merge(gpio_reg, bus.s_wdata, bus.s_mask);
      end
      if (bus.s_we) we_cnt <= we_cnt + 1;
    end
  end

  function automatic obs_t sample();
    obs_t o;
    o        = '0;
    o.gnt0   = bus.m0_gnt;
    o.gnt1   = bus.m1_gnt;
    o.rv0    = bus.m0_rvalid;
    o.rv1    = bus.m1_rvalid;
    o.err0   = bus.m0_rvalid ? bus.m0_err : 1'b0;
    o.err1   = bus.m1_rvalid ? bus.m1_err : 1'b0;
    o.rd0    = bus.m0_rvalid ? bus.m0_rdata : 32'h0;
    o.rd1    = bus.m1_rvalid ? bus.m1_rdata : 32'h0;
    o.saddr  = bus.s_addr;
    o.swdata = bus.s_wdata;
    o.smask  = bus.s_mask;
    o.swe    = bus.s_we;
    o.bsel   = bus.bram_sel;
    o.gsel   = bus.gpio_sel;
    return o;
  endfunction

  function automatic obs_t exp_access(input int m, input bit we, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [3:0] mk, input int r);
    obs_t o;
    o        = '0;
    o.gnt0   = (m == 0);
    o.gnt1   = (m == 1);
    o.saddr  = a;
    o.swdata = wd;
    o.smask  = mk;
    o.swe    = we && (r != 0);
    o.bsel   = (r == 1);
    o.gsel   = (r == 2);
    return o;
  endfunction

  function automatic obs_t exp_resp(input int m, input logic [31:0] rd, input bit err);
    obs_t o;
    o = '0;
    if (m == 0) begin
      o.rv0 = 1'b1; o.rd0 = rd; o.err0 = err;
    end else begin
      o.rv1 = 1'b1; o.rd1 = rd; o.err1 = err;
    end
    return o;
  endfunction

  task automatic check_obs(input obs_t exp, input string name);
    obs_t got;
    got = sample();
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input int got, input int exp, input string name);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive_master(input int m, input bit req, input bit we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] mk);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = wd; bus.m0_mask = mk;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = wd; bus.m1_mask = mk;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1:    return 32'($urandom_range(0, 32'h7FF));
      2:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3));
      3:       return 32'h0000_0800;
      4:       return 32'hFFFF_FFEF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; leaves the bench at a negedge with reset released.
  task automatic do_reset(input bit with_preload, input string name);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    reset      = 1'b1;
    preload    = with_preload;
    #1 check_obs('0, name);
    repeat (2) @(negedge clk);
    reset       = 1'b0;
    preload     = 1'b0;
    mdl_last_m1 = 1'b1;
    if (with_preload) begin
      for (int i = 0; i < 512; i++) mdl_mem[i] = init_word(i);
      mdl_gpio = '0;
    end
  endtask

  // One isolated transfer; starts and ends at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v, input string name);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    drive_master(v.m, 1'b1, v.we, v.addr, v.wdata, v.mask);
    @(negedge clk);
    check_obs(exp_access(v.m, v.we, v.addr, v.wdata, v.mask, v.region), {name, "_access"});
    drive_master(0, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
    drive_master(1, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
    @(negedge clk);
    check_obs(exp_resp(v.m, v.exp_rdata, v.exp_err), {name, "_resp"});
    @(negedge clk);
    check_obs('0, {name, "_idle"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[11];
    vec_t v;
    int   exp_order[4];
    int   snap;
    int   next_free;
    int   acc_cyc;
    obs_t acc_o, resp_o, e;

    //            m  we    addr          wdata         mask  exp_rdata     err   region
    tbl[0]  = '{0, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0, 1};
    tbl[1]  = '{1, 1'b1, 32'hFFFF_FFF0, 32'h0000_0001, 4'hF, 32'h0000_0000, 1'b0, 2};
    tbl[2]  = '{0, 1'b0, 32'h0000_0800, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1, 0};
    tbl[3]  = '{1, 1'b0, 32'h0000_07FF, 32'h0000_0000, 4'hF, 32'h1234_5678, 1'b0, 1};
    tbl[4]  = '{0, 1'b0, 32'hFFFF_FFEF, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1, 0};
    tbl[5]  = '{1, 1'b0, 32'hFFFF_FFF3, 32'h0000_0000, 4'hF, 32'h0000_0001, 1'b0, 2};
    tbl[6]  = '{0, 1'b1, 32'h0000_0020, 32'hA5A5_5A5A, 4'h5, 32'h0000_0000, 1'b0, 1};
    tbl[7]  = '{1, 1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'hC0A5_005A, 1'b0, 1};
    tbl[8]  = '{0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1, 0};
    tbl[9]  = '{1, 1'b1, 32'h0000_07FC, 32'hCAFE_F00D, 4'hC, 32'h0000_0000, 1'b0, 1};
    tbl[10] = '{0, 1'b0, 32'h0000_07FC, 32'h0000_0000, 4'hF, 32'hCAFE_5678, 1'b0, 1};

`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif

    reset = 1'b1;
    preload = 1'b1;
    drive_master(0, 1'b0, 1'b0, '0, '0, '0);
    drive_master(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    do_reset(1'b1, "reset_state");

    // Directed vectors
    snap = we_cnt;
    for (int i = 0; i < 11; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end
    check_int(we_cnt - snap, 3, "vec_write_strobes");

    // Both masters hold requests for four transfers
    do_reset(1'b0, "reset_before_order");
    drive_master(0, 1'b1, 1'b0, 32'h0000_0100, '0, 4'hF);
    drive_master(1, 1'b1, 1'b0, 32'h0000_0104, '0, 4'hF);
    for (int t = 0; t < 4; t++) begin
      int w;
      int waited;
      w = -1;
      waited = 0;
      while (w < 0 && waited < 8) begin
        @(negedge clk);
        waited++;
        if (bus.m0_gnt && bus.m1_gnt) w = 2;
        else if (bus.m0_gnt) w = 0;
        else if (bus.m1_gnt) w = 1;
      end
      check_int(w, exp_order[t], $sformatf("order_t%0d", t));
      check_int(waited, (t == 0) ? 1 : 3, $sformatf("gnt_spacing_t%0d", t));
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    repeat (3) @(negedge clk);
    check_obs('0, "order_quiet");

    // Reset during ACCESS of a BRAM write
    do_reset(1'b0, "reset_before_abort");
    snap = we_cnt;
    drive_master(0, 1'b1, 1'b1, 32'h0000_0040, 32'h1111_2222, 4'hF);
    @(negedge clk);
    check_obs(exp_access(0, 1'b1, 32'h0000_0040, 32'h1111_2222, 4'hF, 1), "abort_access");
    bus.m0_req = 1'b0;
    #2 reset = 1'b1;
    #1 check_obs('0, "abort_async_clear");
    @(negedge clk);
    check_obs('0, "abort_held");
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_obs('0, "abort_no_rvalid");
    end
    check_int(we_cnt - snap, 0, "abort_no_write");
    v = '{0, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'hC0DE_0010, 1'b0, 1};
    run_vec(v, "after_abort");

    // Random traffic against a transaction-level model
    do_reset(1'b1, "reset_before_random");
    next_free = 0;
    acc_cyc   = -10;
    acc_o     = '0;
    resp_o    = '0;
    for (int k = 0; k < 400; k++) begin
      bit          r0, r1, we0, we1;
      logic [31:0] a0, a1, d0, d1;
      logic [3:0]  k0, k1;
      if (k == acc_cyc) e = acc_o;
      else if (k == acc_cyc + 1) e = resp_o;
      else e = '0;
      check_obs(e, $sformatf("rand_cyc%0d", k));

      r0 = ($urandom_range(0, 99) < 45); we0 = 1'($urandom); a0 = rand_addr();
      d0 = $urandom; k0 = 4'($urandom);
      r1 = ($urandom_range(0, 99) < 45); we1 = 1'($urandom); a1 = rand_addr();
      d1 = $urandom; k1 = 4'($urandom);
      drive_master(0, r0, we0, a0, d0, k0);
      drive_master(1, r1, we1, a1, d1, k1);

      if (k + 1 >= next_free && (r0 || r1)) begin
        int          w, rg;
        bit          wwe;
        logic [31:0] wa, wd, rd;
        logic [3:0]  wm;
`ifdef ARB_ROUND_ROBIN_EN
        if (r0 && r1) w = mdl_last_m1 ? 0 : 1;
        else w = r0 ? 0 : 1;
`else
        w = r0 ? 0 : 1;
`endif
        mdl_last_m1 = (w == 1);
        wwe = (w == 0) ? we0 : we1;
        wa  = (w == 0) ? a0 : a1;
        wd  = (w == 0) ? d0 : d1;
        wm  = (w == 0) ? k0 : k1;
        rg  = region_of(wa);
        rd  = 32'h0;
        if (!wwe && rg == 1) rd = mdl_mem[wa[10:2]];
        if (!wwe && rg == 2) rd = mdl_gpio;
        if (wwe && rg == 1) mdl_mem[wa[10:2]] = merge(mdl_mem[wa[10:2]], wd, wm);
        if (wwe && rg == 2) mdl_gpio = merge(mdl_gpio, wd, wm);
        acc_o     = exp_access(w, wwe, wa, wd, wm, rg);
        resp_o    = exp_resp(w, rd, (rg == 0));
        acc_cyc   = k + 1;
        next_free = k + 4;
      end
      @(negedge clk);
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
